// File: rtl/uart_fifo_txrx.sv
// UART transceiver with a first-word-fall-through FIFO in each direction.
// TX drains its FIFO one 8N1-style frame at a time; RX queues good frames and reports BREAKs.

module uart_fifo_txrx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok, pop_ok;

    always_comb begin
        push_ok = push && (count_q != (AW+1)'(DEPTH));
        pop_ok  = pop && (count_q != '0);
        wptr_d  = push_ok ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = pop_ok ? rptr_q + 1'b1 : rptr_q;
        count_d = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr_q] <= push_data;
    end

    assign head  = mem[rptr_q];
    assign empty = (count_q == '0);
    assign full  = (count_q == (AW+1)'(DEPTH));
endmodule

module uart_fifo_txrx #(
    parameter int CLK_HZ       = 25000000,
    parameter int BIT_RATE     = 115200,
    parameter int PAYLOAD_BITS = 8,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    rx,
    output logic                    tx,
    input  logic                    write,
    input  logic [PAYLOAD_BITS-1:0] write_data,
    input  logic                    read,
    output logic [PAYLOAD_BITS-1:0] read_data,
    output logic                    tx_fifo_empty,
    output logic                    tx_fifo_full,
    output logic                    rx_fifo_empty,
    output logic                    rx_fifo_full,
    output logic                    rx_break
);
    localparam int CPB = CLK_HZ / BIT_RATE;
    localparam int CW  = $clog2(CPB + 1);
    localparam int IW  = $clog2(PAYLOAD_BITS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CPB / 2 - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(PAYLOAD_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                  tx_state_q, tx_state_d, rx_state_q, rx_state_d;
    logic [CW-1:0]           tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic [IW-1:0]           tx_idx_q, tx_idx_d, rx_idx_q, rx_idx_d;
    logic [PAYLOAD_BITS-1:0] tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
    logic [PAYLOAD_BITS-1:0] read_data_q, read_data_d, tx_head, rx_head;
    logic                    tx_q, tx_d, rx_break_q, rx_break_d;
    logic                    rx_meta_q, rx_sync_q, rx_prev_q;
    logic                    tx_pop, rx_push;

    uart_fifo_txrx_fifo #(.WIDTH(PAYLOAD_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .reset(reset), .push(write), .push_data(write_data), .pop(tx_pop),
        .head(tx_head), .empty(tx_fifo_empty), .full(tx_fifo_full)
    );

    uart_fifo_txrx_fifo #(.WIDTH(PAYLOAD_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .reset(reset), .push(rx_push), .push_data(rx_shift_q), .pop(read),
        .head(rx_head), .empty(rx_fifo_empty), .full(rx_fifo_full)
    );

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + 1'b1;
        tx_idx_d   = tx_idx_q;
        tx_shift_d = tx_shift_q;
        tx_d       = tx_q;
        tx_pop     = 1'b0;
        case (tx_state_q)
            IDLE: begin
                tx_d     = 1'b1;
                tx_cnt_d = '0;
                if (!tx_fifo_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = tx_head;
                    tx_d       = 1'b0;
                    tx_state_d = START;
                end
            end
            START: if (tx_cnt_q == CNT_LAST) begin
                tx_cnt_d   = '0;
                tx_idx_d   = '0;
                tx_d       = tx_shift_q[0];
                tx_state_d = DATA;
            end
            DATA: if (tx_cnt_q == CNT_LAST) begin
                tx_cnt_d = '0;
                if (tx_idx_q == IDX_LAST) begin
                    tx_d       = 1'b1;
                    tx_state_d = STOP;
                end else begin
                    tx_idx_d   = tx_idx_q + 1'b1;
                    tx_shift_d = tx_shift_q >> 1;
                    tx_d       = tx_shift_d[0];
                end
            end
            STOP: if (tx_cnt_q == CNT_LAST) begin
                tx_cnt_d   = '0;
                tx_state_d = IDLE;
            end
            default: tx_state_d = IDLE;
        endcase
    end

    // Receiver: centre-samples each bit, timing everything from the synchronised falling edge.
    always_comb begin
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q + 1'b1;
        rx_idx_d    = rx_idx_q;
        rx_shift_d  = rx_shift_q;
        rx_push     = 1'b0;
        rx_break_d  = 1'b0;
        read_data_d = (read && !rx_fifo_empty) ? rx_head : read_data_q;
        case (rx_state_q)
            IDLE: begin
                rx_cnt_d = '0;
                if (rx_prev_q && !rx_sync_q) rx_state_d = START;
            end
            START: if (rx_cnt_q == CNT_HALF) begin
                rx_cnt_d   = '0;
                rx_idx_d   = '0;
                rx_state_d = rx_sync_q ? IDLE : DATA;
            end
            DATA: if (rx_cnt_q == CNT_LAST) begin
                rx_cnt_d   = '0;
                rx_shift_d = PAYLOAD_BITS'({rx_sync_q, rx_shift_q} >> 1);
                if (rx_idx_q == IDX_LAST) rx_state_d = STOP;
                else                      rx_idx_d   = rx_idx_q + 1'b1;
            end
            STOP: if (rx_cnt_q == CNT_LAST) begin
                rx_cnt_d   = '0;
                rx_state_d = IDLE;
                if (rx_sync_q)               rx_push    = 1'b1;
                else if (rx_shift_q == '0)   rx_break_d = 1'b1;
            end
            default: rx_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state_q  <= IDLE;
            tx_cnt_q    <= '0;
            tx_idx_q    <= '0;
            tx_shift_q  <= '0;
            tx_q        <= 1'b1;
            rx_state_q  <= IDLE;
            rx_cnt_q    <= '0;
            rx_idx_q    <= '0;
            rx_shift_q  <= '0;
            rx_break_q  <= 1'b0;
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            rx_prev_q   <= 1'b1;
            read_data_q <= '0;
        end else begin
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_idx_q    <= tx_idx_d;
            tx_shift_q  <= tx_shift_d;
            tx_q        <= tx_d;
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_idx_q    <= rx_idx_d;
            rx_shift_q  <= rx_shift_d;
            rx_break_q  <= rx_break_d;
            rx_meta_q   <= rx;
            rx_sync_q   <= rx_meta_q;
            rx_prev_q   <= rx_sync_q;
            read_data_q <= read_data_d;
        end
    end

    assign tx        = tx_q;
    assign rx_break  = rx_break_q;
    assign read_data = read_data_q;
endmodule

// File: tb/tb_uart_fifo_txrx.sv
// Scoreboard bench for uart_fifo_txrx at CPB=10: a tx line decoder pops expected bytes,
// read tasks pop expected RX bytes; each scenario task checks its own results.
`timescale 1ns/1ps
module tb_uart_fifo_txrx;
    localparam int CPB = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_drv = 1'b1;
    logic       loop_en = 1'b0;
    logic       rx;
    logic       tx;
    logic       write = 1'b0;
    logic [7:0] write_data = 8'h00;
    logic       read = 1'b0;
    logic [7:0] read_data;
    logic       tx_fifo_empty, tx_fifo_full, rx_fifo_empty, rx_fifo_full, rx_break;

    int         checks = 0;
    int         failures = 0;
    int         break_cycles = 0;
    logic [7:0] tx_exp_q[$];
    logic [7:0] rx_exp_q[$];

    assign rx = loop_en ? tx : rx_drv;
    always #5 clk = ~clk;

    uart_fifo_txrx #(.CLK_HZ(1000000), .BIT_RATE(100000), .PAYLOAD_BITS(8), .FIFO_DEPTH(8)) dut (
        .clk(clk), .reset(reset), .rx(rx), .tx(tx), .write(write), .write_data(write_data),
        .read(read), .read_data(read_data), .tx_fifo_empty(tx_fifo_empty),
        .tx_fifo_full(tx_fifo_full), .rx_fifo_empty(rx_fifo_empty),
        .rx_fifo_full(rx_fifo_full), .rx_break(rx_break)
    );

    always @(negedge clk) if (rx_break === 1'b1) break_cycles++;

    // tx line decoder: checks bit widths, stop bit, byte order and inter-frame gap
    logic [9:0] mon_bits;
    logic       mon_ragged, mon_abort;
    logic       mon_skip = 1'b0;
    logic [7:0] mon_exp;
    int         mon_gap;
    always begin
        if (!mon_skip) @(negedge clk);
        mon_skip = 1'b0;
        if (reset === 1'b0 && tx === 1'b0) begin
            mon_ragged = 1'b0;
            mon_abort  = 1'b0;
            for (int i = 0; i < 10 * CPB; i++) begin
                if (i > 0) @(negedge clk);
                if (reset !== 1'b0) mon_abort = 1'b1;
                if (i % CPB == 0) mon_bits[i / CPB] = tx;
                else if (tx !== mon_bits[i / CPB]) mon_ragged = 1'b1;
            end
            if (!mon_abort) begin
                checks++;
                if (mon_ragged || mon_bits[9] !== 1'b1) begin
                    failures++;
                    $display("FAIL tx_framing: bits=%b ragged=%0d, required %0d-cycle bits and stop=1", mon_bits, mon_ragged, CPB);
                end
                checks++;
                if (tx_exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL tx_byte: got unexpected frame %02h, required none", mon_bits[8:1]);
                end else begin
                    mon_exp = tx_exp_q.pop_front();
                    if (mon_bits[8:1] !== mon_exp) begin
                        failures++;
                        $display("FAIL tx_byte: got %02h, required %02h", mon_bits[8:1], mon_exp);
                    end else $display("tx frame %02h ok", mon_bits[8:1]);
                end
                if (tx_exp_q.size() > 0) begin
                    mon_gap = 0;
                    while (mon_gap <= 2) begin
                        @(negedge clk);
                        if (tx === 1'b0) break;
                        mon_gap++;
                    end
                    checks++;
                    if (mon_gap > 1) begin
                        failures++;
                        $display("FAIL tx_gap: %0d idle cycles after stop, required <=1", mon_gap);
                    end
                    mon_skip = (tx === 1'b0);
                end
            end
        end
    end

    task automatic do_write(input logic [7:0] d);
        @(negedge clk);
        write = 1'b1;
        write_data = d;
        @(negedge clk);
        write = 1'b0;
        $display("write %02h", d);
    endtask

    task automatic do_read();
        @(negedge clk);
        read = 1'b1;
        @(negedge clk);
        read = 1'b0;
        $display("read -> %02h", read_data);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        logic [9:0] f;
        f = {stop_bit, d, 1'b0};
        for (int b = 0; b < 10; b++) begin
            rx_drv = f[b];
            repeat (CPB) @(negedge clk);
        end
        rx_drv = 1'b1;
        repeat (CPB) @(negedge clk);
        $display("rx frame %02h stop=%0d driven", d, stop_bit);
    endtask

    task automatic wait_tx_drain(input int budget, output logic ok);
        int n;
        n = 0;
        while (tx_exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        ok = (tx_exp_q.size() == 0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx: got %b, required 1", tx); end
        checks++; if (tx_fifo_empty !== 1'b1 || rx_fifo_empty !== 1'b1) begin failures++; $display("FAIL reset_empty: got tx=%b rx=%b, required 1 1", tx_fifo_empty, rx_fifo_empty); end
        checks++; if (tx_fifo_full !== 1'b0 || rx_fifo_full !== 1'b0) begin failures++; $display("FAIL reset_full: got tx=%b rx=%b, required 0 0", tx_fifo_full, rx_fifo_full); end
        checks++; if (read_data !== 8'h00 || rx_break !== 1'b0) begin failures++; $display("FAIL reset_rdata_break: got %02h %b, required 00 0", read_data, rx_break); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (tx !== 1'b1) begin failures++; $display("FAIL post_reset_tx: got %b, required 1", tx); end
        $display("reset checked");
    endtask

    task automatic test_single_tx();
        int   n;
        logic ok;
        tx_exp_q.push_back(8'hA5);
        do_write(8'hA5);
        checks++; if (tx_fifo_empty !== 1'b0) begin failures++; $display("FAIL single_not_empty: got %b, required 0", tx_fifo_empty); end
        n = 0;
        while (tx !== 1'b0 && n < 3) begin
            @(negedge clk);
            n++;
        end
        checks++; if (tx !== 1'b0 || n > 2) begin failures++; $display("FAIL single_start_latency: %0d cycles, required <=2", n); end
        wait_tx_drain(150, ok);
        checks++; if (!ok) begin failures++; $display("FAIL single_drain: %0d pending, required 0", tx_exp_q.size()); tx_exp_q.delete(); end
        repeat (5) @(negedge clk);
        checks++; if (tx_fifo_empty !== 1'b1 || tx !== 1'b1) begin failures++; $display("FAIL single_idle: empty=%b tx=%b, required 1 1", tx_fifo_empty, tx); end
    endtask

    task automatic test_back_to_back();
        int         n;
        logic       ok;
        logic [7:0] d;
        tx_exp_q.push_back(8'h11);
        do_write(8'h11);
        n = 0;
        while (tx !== 1'b0 && n < 5) begin
            @(negedge clk);
            n++;
        end
        checks++; if (tx !== 1'b0) begin failures++; $display("FAIL b2b_busy: tx=%b, required 0", tx); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 7) begin
                checks++; if (tx_fifo_full !== 1'b0) begin failures++; $display("FAIL b2b_full_at7: got %b, required 0", tx_fifo_full); end
            end
            if (i == 8) begin
                checks++; if (tx_fifo_full !== 1'b1) begin failures++; $display("FAIL b2b_full_at8: got %b, required 1", tx_fifo_full); end
            end
            d = 8'h20 + 8'(i * 7);
            write = 1'b1;
            write_data = d;
            if (i < 8) tx_exp_q.push_back(d);
            $display("write %02h (%s)", d, (i < 8) ? "accepted" : "dropped");
        end
        @(negedge clk);
        write = 1'b0;
        checks++; if (tx_fifo_full !== 1'b1) begin failures++; $display("FAIL b2b_full_after: got %b, required 1", tx_fifo_full); end
        wait_tx_drain(1100, ok);
        checks++; if (!ok) begin failures++; $display("FAIL b2b_drain: %0d pending, required 0", tx_exp_q.size()); tx_exp_q.delete(); end
        repeat (5) @(negedge clk);
        checks++; if (tx_fifo_empty !== 1'b1 || tx_fifo_full !== 1'b0) begin failures++; $display("FAIL b2b_final_flags: empty=%b full=%b, required 1 0", tx_fifo_empty, tx_fifo_full); end
    endtask

    task automatic test_loopback();
        int         n;
        logic       ok;
        logic [7:0] e;
        loop_en = 1'b1;
        tx_exp_q.push_back(8'h3C);
        rx_exp_q.push_back(8'h3C);
        do_write(8'h3C);
        n = 0;
        while (rx_fifo_empty !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++; if (rx_fifo_empty !== 1'b0) begin failures++; $display("FAIL loop_rx_arrival: rx_fifo_empty=%b, required 0", rx_fifo_empty); end
        do_read();
        e = rx_exp_q.pop_front();
        checks++; if (read_data !== e) begin failures++; $display("FAIL loop_read_data: got %02h, required %02h", read_data, e); end
        checks++; if (rx_fifo_empty !== 1'b1) begin failures++; $display("FAIL loop_rx_empty: got %b, required 1", rx_fifo_empty); end
        wait_tx_drain(150, ok);
        checks++; if (!ok) begin failures++; $display("FAIL loop_drain: %0d pending, required 0", tx_exp_q.size()); tx_exp_q.delete(); end
        repeat (3) @(negedge clk);
        loop_en = 1'b0;
    endtask

    task automatic test_rx_fill();
        logic [7:0] d, e, last;
        last = 8'h00;
        for (int i = 0; i < 9; i++) begin
            d = 8'h81 + 8'(i * 11);
            if (i < 8) begin
                rx_exp_q.push_back(d);
                last = d;
            end
            send_frame(d, 1'b1);
        end
        checks++; if (rx_fifo_full !== 1'b1 || rx_fifo_empty !== 1'b0) begin failures++; $display("FAIL rxfill_full: full=%b empty=%b, required 1 0", rx_fifo_full, rx_fifo_empty); end
        while (rx_exp_q.size() > 0) begin
            do_read();
            e = rx_exp_q.pop_front();
            checks++; if (read_data !== e) begin failures++; $display("FAIL rxfill_read: got %02h, required %02h", read_data, e); end
        end
        checks++; if (rx_fifo_empty !== 1'b1 || rx_fifo_full !== 1'b0) begin failures++; $display("FAIL rxfill_drained: empty=%b full=%b, required 1 0", rx_fifo_empty, rx_fifo_full); end
        do_read();
        checks++; if (read_data !== last) begin failures++; $display("FAIL rxfill_read_empty: got %02h, required %02h", read_data, last); end
    endtask

    task automatic test_break_glitch();
        int b0;
        b0 = break_cycles;
        rx_drv = 1'b0;
        repeat (12 * CPB) @(negedge clk);
        rx_drv = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        $display("break driven, pulses=%0d", break_cycles - b0);
        checks++; if (break_cycles - b0 != 1) begin failures++; $display("FAIL break_pulse: %0d cycles high, required 1", break_cycles - b0); end
        checks++; if (rx_fifo_empty !== 1'b1) begin failures++; $display("FAIL break_no_push: rx_fifo_empty=%b, required 1", rx_fifo_empty); end
        b0 = break_cycles;
        rx_drv = 1'b0;
        repeat (3) @(negedge clk);
        rx_drv = 1'b1;
        repeat (15 * CPB) @(negedge clk);
        $display("glitch driven");
        checks++; if (rx_fifo_empty !== 1'b1 || break_cycles != b0) begin failures++; $display("FAIL glitch_ignored: empty=%b breaks=%0d, required 1 0", rx_fifo_empty, break_cycles - b0); end
        send_frame(8'h55, 1'b0);
        repeat (CPB) @(negedge clk);
        checks++; if (rx_fifo_empty !== 1'b1 || break_cycles != b0) begin failures++; $display("FAIL bad_stop_discard: empty=%b breaks=%0d, required 1 0", rx_fifo_empty, break_cycles - b0); end
    endtask

    task automatic test_reset_mid_tx();
        int n;
        tx_exp_q.push_back(8'h77);
        tx_exp_q.push_back(8'h78);
        do_write(8'h77);
        do_write(8'h78);
        n = 0;
        while (tx !== 1'b0 && n < 5) begin
            @(negedge clk);
            n++;
        end
        repeat (35) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        $display("reset asserted mid-frame");
        checks++; if (tx !== 1'b1) begin failures++; $display("FAIL midreset_tx: got %b, required 1", tx); end
        checks++; if (tx_fifo_empty !== 1'b1 || tx_fifo_full !== 1'b0 || rx_fifo_empty !== 1'b1 || rx_fifo_full !== 1'b0) begin
            failures++; $display("FAIL midreset_flags: got %b%b%b%b, required 1010", tx_fifo_empty, tx_fifo_full, rx_fifo_empty, rx_fifo_full); end
        checks++; if (read_data !== 8'h00 || rx_break !== 1'b0) begin failures++; $display("FAIL midreset_rdata: got %02h %b, required 00 0", read_data, rx_break); end
        tx_exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        repeat (5 * CPB) @(negedge clk);
        checks++; if (tx !== 1'b1 || tx_fifo_empty !== 1'b1) begin failures++; $display("FAIL midreset_stays_idle: tx=%b empty=%b, required 1 1", tx, tx_fifo_empty); end
    endtask

    initial begin
        test_reset();
        test_single_tx();
        test_back_to_back();
        test_loopback();
        test_rx_fill();
        test_break_glitch();
        test_reset_mid_tx();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded 40000 cycles, required completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/uart_fifo_txrx.md
UART_FIFO_TXRX -- requirements
Module: uart_fifo_txrx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 25000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BIT_RATE, default 115200, serial bit rate in bit/s.
REQ-003 SHALL have parameter PAYLOAD_BITS, default 8, data bits per frame.
REQ-004 SHALL have parameter FIFO_DEPTH, default 8, entries per FIFO (power of two, ≥2).
REQ-005 clk  in  1  system clock; all logic on the rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 rx  in  1  serial receive line, idle high, asynchronous to clk.
REQ-008 tx  out  1  serial transmit line, idle high.
REQ-009 write  in  1  push write_data into the TX FIFO.
REQ-010 write_data  in  PAYLOAD_BITS  byte to transmit.
REQ-011 read  in  1  pop one byte from the RX FIFO.
REQ-012 read_data  out  PAYLOAD_BITS  last popped RX byte.
REQ-013 tx_fifo_empty, tx_fifo_full, rx_fifo_empty, rx_fifo_full  out  1 each  FIFO status flags.
REQ-014 rx_break  out  1  one-cycle pulse when a BREAK frame is received.

Function
REQ-015 Frame format SHALL be 8N1-style: 1 start bit (0), PAYLOAD_BITS data bits LSB first, 1 stop bit (1), no parity.
REQ-016 Bit period SHALL be CPB = CLK_HZ/BIT_RATE clock cycles (integer division), for both TX and RX.
REQ-017 Each FIFO SHALL be synchronous and first-word-fall-through internally, with read/write pointers wrapping modulo FIFO_DEPTH and an occupancy count of 0..FIFO_DEPTH.
REQ-018 Flags SHALL be derived from the count: empty = (count==0), full = (count==FIFO_DEPTH), both valid the cycle after the updating edge.
REQ-019 Simultaneous push and pop on a non-empty, non-full FIFO SHALL both occur with count unchanged.
REQ-020 A push when full SHALL be dropped; a pop when empty SHALL be ignored; no pointer or count change in either case.
REQ-021 write=1 with tx_fifo_full=0 SHALL push write_data at that edge; with tx_fifo_full=1 the byte SHALL be discarded.
REQ-022 The TX FSM SHALL have states IDLE, START, DATA, STOP.
REQ-023 When IDLE and TX FIFO is non-empty, the TX FSM SHALL pop the head byte into a shift register and enter START; tx SHALL fall low no later than 2 cycles after tx_fifo_empty deasserts.
REQ-024 Each TX state SHALL hold tx for exactly CPB cycles; DATA SHALL shift out PAYLOAD_BITS bits; STOP SHALL return to IDLE.
REQ-025 Back-to-back bytes SHALL be sent with at most 1 idle cycle between the stop bit and the next start bit.
REQ-026 rx SHALL pass through a 2-flop synchronizer before use.
REQ-027 The RX FSM SHALL have states IDLE, START, DATA, STOP; a falling edge in IDLE enters START.
REQ-028 RX SHALL sample at CPB/2 into START (if high, return to IDLE as a glitch), then each data and stop bit at one-CPB intervals.
REQ-029 A frame with stop bit 1 SHALL push the byte into the RX FIFO if not full, else drop it.
REQ-030 A frame with stop bit 0 SHALL be discarded; if all data bits were also 0, rx_break SHALL pulse for 1 cycle.
REQ-031 read=1 with rx_fifo_empty=0 SHALL pop the head byte and register it into read_data, valid the next cycle; read while empty SHALL leave read_data unchanged.
REQ-032 read_data SHALL hold its value until the next successful read.

Reset
REQ-033 On reset=1 at a clock edge, the block SHALL clear both FIFOs (pointers and count 0) and force both FSMs to IDLE.
REQ-034 During and after reset, outputs SHALL be tx=1, tx_fifo_empty=1, rx_fifo_empty=1, both full flags=0, read_data=0, rx_break=0.
REQ-035 Reset mid-frame SHALL abort the frame, with tx=1 from the next cycle and no partial RX byte pushed.

Verification (CLK_HZ=1000000, BIT_RATE=100000, CPB=10, FIFO_DEPTH=8)
REQ-036 Write 0xA5 once -> tx shows start 0, bits 1,0,1,0,0,1,0,1, stop 1, each 10 cycles; tx_fifo_empty returns to 1.
REQ-037 Loopback tx->rx, write 0x3C, then read after rx_fifo_empty=0 -> read_data=0x3C the next cycle, rx_fifo_empty=1.
REQ-038 Write 9+ bytes back-to-back while tx is busy -> tx_fifo_full=1 at occupancy 8; extra bytes dropped; transmitted sequence equals the first accepted bytes in order.
REQ-039 Drive 9 frames onto rx without reading -> rx_fifo_full=1; reads then return the first 8 bytes in order, then rx_fifo_empty=1; a read when empty leaves read_data unchanged.
REQ-040 rx held low for 12 bit periods -> one rx_break pulse, no RX FIFO push; a 3-cycle low glitch -> no frame.
REQ-041 Assert reset mid-transmission -> tx=1 next cycle, all flags at reset values, read_data=0.
